// File: rtl/synth_pkg.sv
// Shared definitions for the MIDI note-event producer.
// Contents: MIDI status nibbles, the realtime threshold, the parser/allocator
// FSM state type, and a width helper for down-stream counters.
package synth_pkg;

  localparam logic [3:0] NOTE_ON      = 4'h9;
  localparam logic [3:0] NOTE_OFF     = 4'h8;
  localparam logic [7:0] REALTIME_MIN = 8'hF8;

  typedef enum logic [2:0] {
    IDLE,
    DATA1,
    DATA2,
    SCAN,
    COMMIT,
    HOLD
  } state_t;

  // Bits needed for a counter running 0..n-1 (at least one bit).
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/midi_note_event_gen_if.sv
// Note-event bus between the MIDI byte source and the note-event generator.
// master: drives the byte stream and channel select, observes the note event.
// slave : the generator; consumes bytes, drives busy/overflow and the note
//         event (note_on, cur_key_adr, cur_key_val, cur_vel_on, keys_on).
interface midi_note_event_gen_if #(
  parameter int unsigned VOICES  = 8,
  parameter int unsigned V_WIDTH = 3
);

  logic               midi_byte_valid;
  logic [7:0]         midi_byte;
  logic [3:0]         midi_channel;
  logic               busy;
  logic               overflow;
  logic               note_on;
  logic [V_WIDTH-1:0] cur_key_adr;
  logic [7:0]         cur_key_val;
  logic [7:0]         cur_vel_on;
  logic [VOICES-1:0]  keys_on;

  modport master (
    output midi_byte_valid, midi_byte, midi_channel,
    input  busy, overflow, note_on, cur_key_adr, cur_key_val, cur_vel_on, keys_on
  );

  modport slave (
    input  midi_byte_valid, midi_byte, midi_channel,
    output busy, overflow, note_on, cur_key_adr, cur_key_val, cur_vel_on, keys_on
  );

endinterface

// File: rtl/midi_voice_alloc.sv
// Voice allocator: key table, per-voice gate bitmap and round-robin steal
// pointer.
// Ports:
//   clk, reset  : clock, synchronous active-high reset
//   scan_en     : one voice examined per cycle, index scan_idx (0 first)
//   key         : key number of the current message
//   commit_en   : apply the current message this cycle
//   commit_on   : message is a Note On (else Note Off)
//   keys_on     : per-voice gate bitmap (changes only on commit)
//   hit         : scan found an active voice holding key
//   target      : voice chosen by the scan (match, else free, else steal)
module midi_voice_alloc
  import synth_pkg::*;
#(
  parameter int unsigned VOICES  = 8,
  parameter int unsigned V_WIDTH = 3
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               scan_en,
  input  logic [V_WIDTH-1:0] scan_idx,
  input  logic [6:0]         key,
  input  logic               commit_en,
  input  logic               commit_on,
  output logic [VOICES-1:0]  keys_on,
  output logic               hit,
  output logic [V_WIDTH-1:0] target
);

  logic [6:0]         key_tab [VOICES];
  logic               m_found, f_found;
  logic [V_WIDTH-1:0] m_idx, f_idx, steal_ptr;
  logic               hit_now, free_now, first;

  always_comb begin
    hit_now  = keys_on[scan_idx] && (key_tab[scan_idx] == key);
    free_now = !keys_on[scan_idx];
    first    = (scan_idx == '0);
  end

  assign hit = m_found;

  always_comb begin
    target = steal_ptr;
    if (m_found)      target = m_idx;
    else if (f_found) target = f_idx;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      keys_on   <= '0;
      m_found   <= 1'b0;
      f_found   <= 1'b0;
      m_idx     <= '0;
      f_idx     <= '0;
      steal_ptr <= '0;
      for (int unsigned i = 0; i < VOICES; i++) key_tab[i] <= '0;
    end else begin
      if (scan_en) begin
        // Voice 0 restarts the search; later voices only fill an empty slot,
        // so the lowest matching/free index wins.
        if ((first || !m_found) && hit_now) begin
          m_found <= 1'b1;
          m_idx   <= scan_idx;
        end else if (first) begin
          m_found <= 1'b0;
        end
        if ((first || !f_found) && free_now) begin
          f_found <= 1'b1;
          f_idx   <= scan_idx;
        end else if (first) begin
          f_found <= 1'b0;
        end
      end
      if (commit_en) begin
        if (commit_on) begin
          key_tab[target] <= key;
          keys_on[target] <= 1'b1;
          if (!m_found && !f_found) steal_ptr <= steal_ptr + 1'b1;
        end else if (m_found) begin
          keys_on[m_idx] <= 1'b0;
        end
      end
    end
  end

endmodule

// File: rtl/midi_note_event_gen.sv
// MIDI note-event generator: parses a MIDI byte stream, extracts Note On/Off
// for one channel, allocates a voice and presents the event frozen for
// HOLD_CYCLES so a slower domain can capture it with a two-flop sync.
// Ports:
//   sys_clk : sole clock
//   reset   : synchronous active-high reset
//   bus     : slave side of midi_note_event_gen_if (byte input, channel,
//             busy/overflow, note_on, cur_key_adr/val, cur_vel_on, keys_on)
module midi_note_event_gen
  import synth_pkg::*;
#(
  parameter int unsigned VOICES      = 8,
  parameter int unsigned V_WIDTH     = 3,
  parameter int unsigned HOLD_CYCLES = 2048
) (
  input logic                 sys_clk,
  input logic                 reset,
  midi_note_event_gen_if.slave bus
);

  localparam int unsigned HW = cnt_width(HOLD_CYCLES);

  state_t             state;
  logic [3:0]         status_hi;
  logic               rs_valid;
  logic [6:0]         key;
  logic [7:0]         vel;
  logic [V_WIDTH-1:0] scan_idx;
  logic [HW-1:0]      hold_cnt;
  logic               note_on, overflow;
  logic [V_WIDTH-1:0] cur_key_adr;
  logic [7:0]         cur_key_val, cur_vel_on;
  logic [VOICES-1:0]  keys_on;
  logic               busy, accept, is_rt, is_note, commit_on, hit;
  logic [V_WIDTH-1:0] target;

  always_comb begin
    busy      = (state == SCAN) || (state == COMMIT) || (state == HOLD);
    accept    = bus.midi_byte_valid && !busy;
    is_rt     = (bus.midi_byte >= REALTIME_MIN);
    is_note   = ((bus.midi_byte[7:4] == NOTE_ON) || (bus.midi_byte[7:4] == NOTE_OFF))
                && (bus.midi_byte[3:0] == bus.midi_channel);
    commit_on = (status_hi == NOTE_ON) && (vel != '0);
  end

  midi_voice_alloc #(
    .VOICES (VOICES),
    .V_WIDTH(V_WIDTH)
  ) u_alloc (
    .clk      (sys_clk),
    .reset    (reset),
    .scan_en  (state == SCAN),
    .scan_idx (scan_idx),
    .key      (key),
    .commit_en(state == COMMIT),
    .commit_on(commit_on),
    .keys_on  (keys_on),
    .hit      (hit),
    .target   (target)
  );

  always_ff @(posedge sys_clk) begin
    if (reset) begin
      state       <= IDLE;
      status_hi   <= '0;
      rs_valid    <= 1'b0;
      key         <= '0;
      vel         <= '0;
      scan_idx    <= '0;
      hold_cnt    <= '0;
      note_on     <= 1'b0;
      overflow    <= 1'b0;
      cur_key_adr <= '0;
      cur_key_val <= '0;
      cur_vel_on  <= '0;
    end else begin
      if (bus.midi_byte_valid && busy) overflow <= 1'b1;
      case (state)
        IDLE, DATA1, DATA2: begin
          if (accept && !is_rt) begin
            if (bus.midi_byte[7]) begin
              if (is_note) begin
                status_hi <= bus.midi_byte[7:4];
                rs_valid  <= 1'b1;
                state     <= DATA1;
              end else begin
                rs_valid <= 1'b0;
                state    <= IDLE;
              end
            end else if (state == DATA2) begin
              vel      <= bus.midi_byte;
              scan_idx <= '0;
              state    <= SCAN;
            end else if ((state == DATA1) || rs_valid) begin
              // In IDLE a data byte under running status acts as data1.
              key   <= bus.midi_byte[6:0];
              state <= DATA2;
            end
          end
        end
        SCAN: begin
          scan_idx <= scan_idx + 1'b1;
          if (scan_idx == V_WIDTH'(VOICES - 1)) state <= COMMIT;
        end
        COMMIT: begin
          hold_cnt <= '0;
          if (commit_on) begin
            note_on     <= 1'b1;
            cur_key_adr <= target;
            cur_key_val <= {1'b0, key};
            cur_vel_on  <= vel;
            state       <= HOLD;
          end else if (hit) begin
            cur_key_adr <= target;
            cur_key_val <= {1'b0, key};
            state       <= HOLD;
          end else begin
            state <= IDLE;
          end
        end
        HOLD: begin
          if (hold_cnt == HW'(HOLD_CYCLES - 1)) begin
            note_on <= 1'b0;
            state   <= IDLE;
          end else begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy        = busy;
  assign bus.overflow    = overflow;
  assign bus.note_on     = note_on;
  assign bus.cur_key_adr = cur_key_adr;
  assign bus.cur_key_val = cur_key_val;
  assign bus.cur_vel_on  = cur_vel_on;
  assign bus.keys_on     = keys_on;

endmodule
